engine_arbiter: RTL and testbench

Two-client round-robin arbiter that shares a single compute engine (start/done handshake) between two requesters. Sits between two controller front-ends and one engine instance. Latches the winner's operand, issues one engine start pulse, waits for engine completion, and returns the result to the winner with a one-cycle done pulse. Optional watchdog aborts a hung engine transaction.

---
 rtl/engine_arbiter.sv | 132 +++++++++++++
 tb/tb_engine_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/engine_arbiter.sv
// Two-client round-robin arbiter in front of one start/done compute engine.
// Optional watchdog abort of a hung engine transaction: define ENGINE_TIMEOUT_EN.
module engine_arbiter #(
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] opnd0,
    input  logic [W-1:0] opnd1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] result,
    output logic         err,
    output logic         eng_start,
    output logic [W-1:0] eng_opnd,
    input  logic         eng_done,
    input  logic [W-1:0] eng_result
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

    state_e         state_q, state_d;
    logic           sel_q, sel_d;     // served requester: 0 -> req0, 1 -> req1
    logic           ptr_q, ptr_d;     // requester favoured on a tie
    logic [W-1:0]   result_q, result_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic           pick;

    assign pick = (req0 && req1) ? ptr_q : !req0;

`ifdef ENGINE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       abort_q, abort_d;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        result_d = result_q;
        opnd_d   = opnd_q;
`ifdef ENGINE_TIMEOUT_EN
        cnt_d    = cnt_q;
        abort_d  = abort_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d   = pick;
                    opnd_d  = pick ? opnd1 : opnd0;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef ENGINE_TIMEOUT_EN
                cnt_d   = 8'd0;
                abort_d = 1'b0;
`endif
            end
            WAIT: begin
                // A completion in the expiry cycle still wins over the abort.
                if (eng_done) begin
                    result_d = eng_result;
                    state_d  = RESP;
                end
`ifdef ENGINE_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    result_d = '0;
                    abort_d  = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                ptr_d   = ~sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            ptr_q    <= 1'b0;
            result_q <= '0;
            opnd_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            result_q <= result_d;
            opnd_q   <= opnd_d;
        end
    end

`ifdef ENGINE_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= 8'd0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    assign err = abort_q && (state_q == RESP);
`else
    assign err = 1'b0;
`endif

    // All outputs decode from registered state only.
    assign gnt0      = (state_q != IDLE) && !sel_q;
    assign gnt1      = (state_q != IDLE) &&  sel_q;
    assign done0     = (state_q == RESP) && !sel_q;
    assign done1     = (state_q == RESP) &&  sel_q;
    assign eng_start = (state_q == START);
    assign eng_opnd  = opnd_q;
    assign result    = result_q;

endmodule

// File: tb/tb_engine_arbiter.sv
// Directed self-checking bench for engine_arbiter; expected values are hand-derived.
module tb_engine_arbiter;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] opnd0 = '0, opnd1 = '0;
    logic         gnt0, gnt1, done0, done1, err, eng_start;
    logic [W-1:0] result, eng_opnd;
    logic         eng_done = 1'b0;
    logic [W-1:0] eng_result = '0;

    int nvec = 0;
    int nerr = 0;

    engine_arbiter #(.W(W), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .opnd0(opnd0), .opnd1(opnd1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .err(err),
        .eng_start(eng_start), .eng_opnd(eng_opnd),
        .eng_done(eng_done), .eng_result(eng_result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts in an IDLE cycle with requests already driven; ends in the following IDLE cycle.
    task automatic serve(input int who, input logic [7:0] op, input logic [7:0] res,
                         input int lat, input bit drop);
        tick();
        chk("gnt0", gnt0, who == 0);
        chk("gnt1", gnt1, who == 1);
        chk("start", eng_start, 1);
        chk("eng_opnd", eng_opnd, op);
        tick();
        chk("start_once", eng_start, 0);
        repeat (lat - 1) tick();
        eng_done = 1'b1;
        eng_result = res;
        tick();
        eng_done = 1'b0;
        chk("done0", done0, who == 0);
        chk("done1", done1, who == 1);
        chk("result", result, res);
        chk("err", err, 0);
        tick();
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        chk("done0_off", done0, 0);
        chk("done1_off", done1, 0);
        chk("gnt0_off", gnt0, 0);
        chk("gnt1_off", gnt1, 0);
    endtask

    initial begin
        bit seen_err, seen_done;
        #1;
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_result", result, 0);
        chk("rst_opnd", eng_opnd, 0);
        chk("rst_err", err, 0);
        tick();
        reset = 1'b0;

        // single req0, engine answers two cycles after start
        req0 = 1'b1; opnd0 = 8'h5A;
        serve(0, 8'h5A, 8'hA5, 2, 1);

        // round robin after reset with both requesting continuously
        reset = 1'b1; tick(); reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; opnd0 = 8'h44; opnd1 = 8'h33;
        serve(0, 8'h44, 8'h01, 1, 0);
        serve(1, 8'h33, 8'h02, 1, 0);
        serve(0, 8'h44, 8'h03, 1, 0);
        serve(1, 8'h33, 8'h04, 1, 1);

        // eng_done during START ignored; held three cycles gives one done
        req0 = 1'b1; opnd0 = 8'h01;
        eng_done = 1'b1; eng_result = 8'h99;
        tick();
        chk("st_gnt0", gnt0, 1);
        tick();
        eng_done = 1'b0;
        chk("st_ignored", done0, 0);
        chk("st_result", result, 8'h04);
        tick();
        eng_done = 1'b1; eng_result = 8'h7E;
        tick();
        chk("hold_done", done0, 1);
        chk("hold_result", result, 8'h7E);
        tick();
        req0 = 1'b0;
        chk("hold_once", done0, 0);
        tick();
        eng_done = 1'b0;
        chk("hold_idle", {done0, gnt0, eng_start}, 0);

        // operand change during WAIT does not reach the engine
        req0 = 1'b1; opnd0 = 8'h11;
        tick();
        chk("lat_opnd", eng_opnd, 8'h11);
        tick();
        opnd0 = 8'h22;
        tick();
        chk("keep_opnd", eng_opnd, 8'h11);
        eng_done = 1'b1; eng_result = 8'h5C;
        tick();
        eng_done = 1'b0;
        chk("keep_done", done0, 1);
        chk("keep_opnd2", eng_opnd, 8'h11);
        tick();
        req0 = 1'b0;

        // reset in WAIT
        req0 = 1'b1; opnd0 = 8'h77;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("async_rst", {gnt0, gnt1, done0, done1, eng_start, err}, 0);
        tick();
        req0 = 1'b0;
        chk("mid_rst_result", result, 0);
        chk("mid_rst_opnd", eng_opnd, 0);
        reset = 1'b0;
        tick();
        chk("mid_rst_done", {done0, done1, gnt0}, 0);
        req1 = 1'b1; opnd1 = 8'h33;
        serve(1, 8'h33, 8'h3C, 1, 1);
        req0 = 1'b1; req1 = 1'b1; opnd0 = 8'h66;
        serve(0, 8'h66, 8'h42, 1, 0);
        serve(1, 8'h33, 8'h24, 1, 1);

`ifdef ENGINE_TIMEOUT_EN
        // silent engine: abort after four WAIT cycles
        req0 = 1'b1; opnd0 = 8'h10;
        tick(); tick();
        repeat (3) tick();
        chk("to_early", {done0, err}, 0);
        tick();
        chk("to_done", done0, 1);
        chk("to_err", err, 1);
        chk("to_result", result, 0);
        tick();
        req0 = 1'b0;
        chk("to_clear", {done0, err}, 0);
`else
        // silent engine: arbiter waits indefinitely
        req0 = 1'b1; opnd0 = 8'h10;
        tick(); tick();
        seen_err = 1'b0; seen_done = 1'b0;
        repeat (100) begin
            tick();
            if (err) seen_err = 1'b1;
            if (done0 || done1) seen_done = 1'b1;
        end
        chk("wait_err", seen_err, 0);
        chk("wait_done", seen_done, 0);
        chk("wait_gnt", gnt0, 1);
        eng_done = 1'b1; eng_result = 8'hC3;
        tick();
        eng_done = 1'b0;
        chk("late_done", done0, 1);
        chk("late_result", result, 8'hC3);
        tick();
        req0 = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
